// File: rtl/cnn_mmio_slave.sv
// CPU-side register window for cnn_accelerator on a PicoRV32-style native bus.
// Holds the input map, sequences start/done and keeps a sticky status word.
module cnn_mmio_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          N_IN      = 36,
  parameter int          N_OUT     = 9,
  parameter int          DATA_W    = 16,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mem_valid,
  output logic                           mem_ready,
  input  logic [31:0]                    mem_addr,
  input  logic [31:0]                    mem_wdata,
  input  logic [3:0]                     mem_wstrb,
  output logic [31:0]                    mem_rdata,
  output logic                           start,
  input  logic                           done,
  output logic [N_IN-1:0][DATA_W-1:0]    feature_map_in,
  input  logic [N_OUT-1:0][DATA_W-1:0]   feature_map_out
);

  localparam int CTRL_OFF   = 100;
  localparam int STATUS_OFF = 101;
  localparam int CNT_W      = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t                             state_reg;
  logic [CNT_W-1:0]                   cnt_reg;
  logic                               done_flag_reg;
  logic                               timeout_flag_reg;
  logic [DATA_W-1:0]                  fmap_in_reg [N_IN];
  logic [N_OUT-1:0][DATA_W-1:0]       fmap_out_reg;
  logic [31:0]                        rdata_next;

  logic [31:0] rel_addr;
  logic        hit;
  logic [6:0]  off;
  logic        accept;
  logic        is_wr;
  logic        fmap_in_wr;
  logic        ctrl_start;
  logic        status_wr;
  logic        unused_wdata;

  assign rel_addr = mem_addr - BASE_ADDR;
  assign hit      = (mem_addr >= BASE_ADDR) && (rel_addr < 32'd512);
  assign off      = rel_addr[8:2];
  // The CPU keeps valid high during the ready cycle, so that cycle is never a new request.
  assign accept   = mem_valid && !mem_ready;
  assign is_wr    = (mem_wstrb != 4'b0000);

  assign fmap_in_wr = accept && is_wr && hit && (off < 7'(N_IN)) && (state_reg == IDLE);
  assign ctrl_start = accept && is_wr && hit && (off == 7'(CTRL_OFF)) && mem_wdata[0];
  assign status_wr  = accept && is_wr && hit && (off == 7'(STATUS_OFF));

  assign unused_wdata = ^mem_wdata[31:DATA_W];

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_fmap_in
      always_ff @(posedge clk) begin
        if (reset) begin
          fmap_in_reg[gi] <= '0;
        end else if (fmap_in_wr && (off == 7'(gi))) begin
          if (mem_wstrb[0]) fmap_in_reg[gi][7:0]        <= mem_wdata[7:0];
          if (mem_wstrb[1]) fmap_in_reg[gi][DATA_W-1:8] <= mem_wdata[DATA_W-1:8];
        end
      end
      assign feature_map_in[gi] = fmap_in_reg[gi];
    end
  endgenerate

  always_comb begin
    rdata_next = '0;
    if (hit) begin
      for (int i = 0; i < N_IN; i++)
        if (off == 7'(i)) rdata_next = 32'(fmap_in_reg[i]);
      for (int i = 0; i < N_OUT; i++)
        if (off == 7'(N_IN + i)) rdata_next = 32'(fmap_out_reg[i]);
      if (off == 7'(STATUS_OFF))
        rdata_next = {29'b0, timeout_flag_reg, (state_reg != IDLE), done_flag_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready        <= 1'b0;
      mem_rdata        <= '0;
      start            <= 1'b0;
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      done_flag_reg    <= 1'b0;
      timeout_flag_reg <= 1'b0;
      fmap_out_reg     <= '0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= (accept && !is_wr) ? rdata_next : 32'd0;
      start     <= 1'b0;

      if (status_wr) begin
        if (mem_wdata[0]) done_flag_reg    <= 1'b0;
        if (mem_wdata[2]) timeout_flag_reg <= 1'b0;
      end

      // FSM updates come after the clear writes so a same-edge set wins.
      case (state_reg)
        IDLE: begin
          if (ctrl_start) begin
            state_reg        <= START;
            start            <= 1'b1;
            done_flag_reg    <= 1'b0;
            timeout_flag_reg <= 1'b0;
          end
        end
        START: begin
          cnt_reg   <= '0;
          state_reg <= BUSY;
        end
        BUSY: begin
          if (done) begin
            fmap_out_reg  <= feature_map_out;
            done_flag_reg <= 1'b1;
            state_reg     <= IDLE;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            timeout_flag_reg <= 1'b1;
            state_reg        <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_mmio_slave.sv
// Scoreboard bench for cnn_mmio_slave: bus transactions queue their expected
// read data, which is popped and compared when the one-cycle ack arrives.
module tb_cnn_mmio_slave;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam int          TIMEOUT = 1024;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;
  logic [31:0]          mem_rdata;
  logic                 start;
  logic                 done;
  logic [35:0][15:0]    feature_map_in;
  logic [8:0][15:0]     feature_map_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cnt    = 0;
  int start_cyc    = 0;
  int start_double = 0;
  logic prev_start = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
    bit          is_rd;
  } exp_t;
  exp_t sb[$];

  cnn_mmio_slave dut (
    .clk             (clk),
    .reset           (reset),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_rdata       (mem_rdata),
    .start           (start),
    .done            (done),
    .feature_map_in  (feature_map_in),
    .feature_map_out (feature_map_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
      if (prev_start) start_double++;
    end
    prev_start = start;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One bus request; the ack must come exactly one cycle later, and the
  // still-held valid during the ack cycle must not produce a second ack.
  task automatic bus(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.exp = exp; e.is_rd = (wstrb == 4'b0000);
    sb.push_back(e);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    @(posedge clk); #1;
    chk({tag, "_ack"}, 32'(mem_ready), 32'd1);
    e = sb.pop_front();
    if (mem_ready && e.is_rd) chk(e.tag, mem_rdata, e.exp);
    $display("xact %s addr=%h wdata=%h wstrb=%b rdata=%h", tag, addr, wdata, wstrb, mem_rdata);
    @(posedge clk); #1;
    chk({tag, "_noreack"}, 32'(mem_ready), 32'd0);
    mem_valid = 1'b0; mem_wstrb = 4'b0000;
  endtask

  function automatic logic [31:0] wa(input int off);
    return BASE + 32'(off * 4);
  endfunction

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    done = 1'b0; feature_map_out = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    @(negedge clk); reset = 1'b0;

    // reset contents
    bus("rd_in0",     wa(0),   0, 4'b0000, 32'd0);
    bus("rd_out0",    wa(36),  0, 4'b0000, 32'd0);
    bus("rd_status",  wa(101), 0, 4'b0000, 32'd0);

    // byte lanes
    bus("wr5_lane0",  wa(5), 32'h0000_ABCD, 4'b0001, 0);
    bus("rd5_lane0",  wa(5), 0, 4'b0000, 32'h0000_00CD);
    bus("wr5_lane01", wa(5), 32'h0000_1234, 4'b0011, 0);
    bus("rd5_lane01", wa(5), 0, 4'b0000, 32'h0000_1234);
    bus("wr6_full",   wa(6), 32'hFFFF_5678, 4'b1111, 0);
    bus("rd6_full",   wa(6), 0, 4'b0000, 32'h0000_5678);

    // misc decode
    bus("rd_ctrl",    wa(100), 0, 4'b0000, 32'd0);
    bus("wr_unmap",   wa(50), 32'hFFFF_FFFF, 4'b1111, 0);
    bus("rd_unmap",   wa(50), 0, 4'b0000, 32'd0);
    bus("rd_miss_lo", BASE - 32'd4, 0, 4'b0000, 32'd0);
    bus("rd_top",     wa(127), 0, 4'b0000, 32'd0);

    // ramp, start, busy-time writes, done
    for (int k = 0; k < 36; k++) bus("wr_ramp", wa(k), 32'(k + 1), 4'b0011, 0);
    chk("fmap_in0",  32'(feature_map_in[0]),  32'd1);
    chk("fmap_in35", 32'(feature_map_in[35]), 32'd36);
    bus("wr_ctrl",     wa(100), 32'd1, 4'b1111, 0);
    bus("rd_st_busy",  wa(101), 0, 4'b0000, 32'h2);
    chk("start_cnt1",  32'(start_cnt), 32'd1);
    bus("wr0_busy",    wa(0), 32'h0000_FFFF, 4'b0011, 0);
    bus("wr_ctrl_busy", wa(100), 32'd1, 4'b1111, 0);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 9; k++) feature_map_out[k] = 16'(k + 100);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    bus("rd_st_done",  wa(101), 0, 4'b0000, 32'h1);
    chk("start_cnt_b", 32'(start_cnt), 32'd1);
    chk("start_width", 32'(start_double), 32'd0);
    bus("rd0_kept",    wa(0), 0, 4'b0000, 32'd1);
    for (int k = 0; k < 9; k++) bus("rd_out", wa(36 + k), 0, 4'b0000, 32'(k + 100));

    // done while idle must not recapture; FMAP_OUT is read-only
    for (int k = 0; k < 9; k++) feature_map_out[k] = 16'hBEEF;
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    bus("rd_out_nocap", wa(36), 0, 4'b0000, 32'd100);
    bus("wr_out_ro",    wa(37), 32'h5555, 4'b0011, 0);
    bus("rd_out_ro",    wa(37), 0, 4'b0000, 32'd101);
    bus("wr_clr_done",  wa(101), 32'h1, 4'b1111, 0);
    bus("rd_st_clr",    wa(101), 0, 4'b0000, 32'd0);

    // timeout
    bus("wr_ctrl_to",   wa(100), 32'd1, 4'b1111, 0);
    chk("start_cnt2",   32'(start_cnt), 32'd2);
    while (cyc < start_cyc + TIMEOUT - 10) @(negedge clk);
    bus("rd_st_late",   wa(101), 0, 4'b0000, 32'h2);
    while (cyc < start_cyc + TIMEOUT + 5) @(negedge clk);
    bus("rd_st_to",     wa(101), 0, 4'b0000, 32'h4);
    bus("wr_clr_to",    wa(101), 32'h4, 4'b1111, 0);
    bus("rd_st_toclr",  wa(101), 0, 4'b0000, 32'd0);

    // reset while busy, with a request pending in the same cycle
    bus("wr_ctrl_rst",  wa(100), 32'd1, 4'b1111, 0);
    repeat (4) @(negedge clk);
    reset = 1'b1; mem_valid = 1'b1; mem_addr = wa(101); mem_wstrb = 4'b0000;
    @(posedge clk); #1;
    chk("rst_mid_ready", 32'(mem_ready), 32'd0);
    chk("rst_mid_start", 32'(start), 32'd0);
    chk("rst_mid_fmap",  32'(feature_map_in == '0), 32'd1);
    @(negedge clk); reset = 1'b0; mem_valid = 1'b0;
    bus("rd_st_rst",    wa(101), 0, 4'b0000, 32'd0);
    bus("rd_miss_hi",   BASE + 32'h400, 0, 4'b0000, 32'd0);
    bus("rd_in_rst",    wa(10), 0, 4'b0000, 32'd0);
    bus("rd_out_rst",   wa(36), 0, 4'b0000, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
